// File: rtl/conv_sequencer_pkg.sv
// Shared types and widths for the convolution sequencer and its index counter.
package conv_sequencer_pkg;

   localparam int ACC_W = 24;
   localparam int IDX_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/matrix_index_counter.sv
// Nested x/y window counter (y inner, x outer) with clear, enable and last-index flag.
// Registered indices; last_o decodes the current registered position.
module matrix_index_counter
   import conv_sequencer_pkg::*;
#(
   parameter logic [IDX_W-1:0] SIZE = 4'd3
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [IDX_W-1:0] x_o,
   output logic [IDX_W-1:0] y_o,
   output logic             last_o
);

   localparam logic [IDX_W-1:0] MAX = SIZE - 4'd1;

   logic [IDX_W-1:0] x_q, x_d;
   logic [IDX_W-1:0] y_q, y_d;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clr_i) begin
         x_d = '0;
         y_d = '0;
      end else if (en_i) begin
         if (y_q == MAX) begin
            y_d = '0;
            x_d = x_q + 4'd1;
         end else begin
            y_d = y_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x_o    = x_q;
   assign y_o    = y_q;
   assign last_o = (x_q == MAX) && (y_q == MAX);

endmodule

// File: rtl/conv_sequencer.sv
// Walks a SIZE x SIZE window issuing read strobes and accumulates kernel*pixel products.
// Result valid SIZE*SIZE+2 cycles after start; held until result_ready, no timeout.
module conv_sequencer
   import conv_sequencer_pkg::*;
#(
   parameter logic [IDX_W-1:0] SIZE = 4'd3
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic [IDX_W-1:0] cur_x,
   output logic [IDX_W-1:0] cur_y,
   output logic             en_strobe,
   input  logic [7:0]       kernel_v,
   input  logic [7:0]       pixel_v,
   output logic [ACC_W-1:0] result,
   output logic             result_valid,
   input  logic             result_ready
);

   state_t           state_q;
   logic             busy_q;
   logic             en_strobe_q;
   logic             pend_q;
   logic             result_valid_q;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] result_q;
   logic [15:0]      prod;
   logic             idx_clr;
   logic             idx_en;
   logic             idx_last;

   // Counter holds on the last index so cur_x/cur_y keep their final value after ISSUE.
   assign idx_clr = (state_q == IDLE) && start;
   assign idx_en  = (state_q == ISSUE) && !idx_last;

   matrix_index_counter #(.SIZE(SIZE)) u_idx (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (idx_clr),
      .en_i   (idx_en),
      .x_o    (cur_x),
      .y_o    (cur_y),
      .last_o (idx_last)
   );

   // Read data arrives the cycle after each strobe, tracked by pend_q.
   assign prod  = kernel_v * pixel_v;
   assign acc_d = acc_q + (pend_q ? ACC_W'(prod) : '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         busy_q         <= 1'b0;
         en_strobe_q    <= 1'b0;
         pend_q         <= 1'b0;
         acc_q          <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         pend_q <= en_strobe_q;
         acc_q  <= acc_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q     <= ISSUE;
                  busy_q      <= 1'b1;
                  en_strobe_q <= 1'b1;
                  acc_q       <= '0;
               end
            end
            ISSUE: begin
               if (idx_last) begin
                  state_q     <= DRAIN;
                  en_strobe_q <= 1'b0;
               end
            end
            DRAIN: begin
               state_q        <= DONE;
               result_q       <= acc_d;
               result_valid_q <= 1'b1;
            end
            DONE: begin
               if (result_ready) begin
                  state_q        <= IDLE;
                  busy_q         <= 1'b0;
                  result_valid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy         = busy_q;
   assign en_strobe    = en_strobe_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer (SIZE=3 instance randomized, SIZE=1 instance directed).
module tb_conv_sequencer;

   typedef struct {int x; int y; int cyc;} strb_t;
   typedef struct {int res; int cyc;} exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start3 = 1'b0, ready3 = 1'b0;
   logic        busy3, en3, rv3;
   logic [3:0]  cx3, cy3;
   logic [7:0]  kv3 = '0, pv3 = '0;
   logic [23:0] res3;
   logic        start1 = 1'b0, ready1 = 1'b0;
   logic        busy1, en1, rv1;
   logic [3:0]  cx1, cy1;
   logic [7:0]  kv1 = '0, pv1 = '0;
   logic [23:0] res1;

   logic [7:0]  kmem [3][3];
   logic [7:0]  pmem [3][3];
   strb_t       sq [$];
   exp_t        rq [$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic        prev_rv = 1'b0;
   logic [23:0] held = '0;

   conv_sequencer #(.SIZE(4'd3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .busy(busy3), .cur_x(cx3), .cur_y(cy3),
      .en_strobe(en3), .kernel_v(kv3), .pixel_v(pv3), .result(res3),
      .result_valid(rv3), .result_ready(ready3)
   );

   conv_sequencer #(.SIZE(4'd1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .busy(busy1), .cur_x(cx1), .cur_y(cy1),
      .en_strobe(en1), .kernel_v(kv1), .pixel_v(pv1), .result(res1),
      .result_valid(rv1), .result_ready(ready1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Index/read blocks: register the addressed element on each strobe.
   always @(posedge clk) begin
      if (en3) begin
         kv3 <= kmem[cx3][cy3];
         pv3 <= pmem[cx3][cy3];
      end
      if (en1) begin
         kv1 <= 8'd7;
         pv1 <= 8'd6;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Reference model: expected window order, strobe cycles and dot-product sum.
   task automatic issue_start;
      int s;
      s = 0;
      for (int x = 0; x < 3; x++)
         for (int y = 0; y < 3; y++) begin
            s += int'(kmem[x][y]) * int'(pmem[x][y]);
            sq.push_back('{x, y, cyc + 1 + x * 3 + y});
         end
      rq.push_back('{s, cyc + 3 * 3 + 2});
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
   endtask

   task automatic wait_valid;
      int i;
      i = 0;
      while (!rv3 && i < 100) begin
         tick();
         i++;
      end
      if (!rv3) fail_now("result_valid_timeout");
   endtask

   task automatic wait_result(input int hold);
      wait_valid();
      repeat (hold) tick();
      ready3 = 1'b1;
      tick();
      ready3 = 1'b0;
      check("busy_after_accept", {31'd0, busy3}, 32'd0);
      check("valid_after_accept", {31'd0, rv3}, 32'd0);
   endtask

   task automatic fill_random;
      for (int x = 0; x < 3; x++)
         for (int y = 0; y < 3; y++) begin
            kmem[x][y] = 8'($urandom_range(0, 255));
            pmem[x][y] = 8'($urandom_range(0, 255));
         end
   endtask

   task automatic fill_const(input logic [7:0] k, input logic [7:0] p);
      for (int x = 0; x < 3; x++)
         for (int y = 0; y < 3; y++) begin
            kmem[x][y] = k;
            pmem[x][y] = p;
         end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, {31'd0, busy3}, 32'd0);
      check({tag, "_en_strobe"}, {31'd0, en3}, 32'd0);
      check({tag, "_result_valid"}, {31'd0, rv3}, 32'd0);
      check({tag, "_result"}, {8'd0, res3}, 32'd0);
      check({tag, "_cur_x"}, {28'd0, cx3}, 32'd0);
      check({tag, "_cur_y"}, {28'd0, cy3}, 32'd0);
   endtask

   // Monitor: strobe order/timing and result value/latency/stability.
   always @(negedge clk) begin
      if (rst) begin
         prev_rv = 1'b0;
      end else begin
         if (en3) begin
            if (sq.size() == 0) fail_now("unexpected_strobe");
            else begin
               strb_t e;
               e = sq.pop_front();
               check("strobe_x", {28'd0, cx3}, e.x);
               check("strobe_y", {28'd0, cy3}, e.y);
               check("strobe_cycle", cyc, e.cyc);
            end
         end
         if (rv3 && !prev_rv) begin
            if (rq.size() == 0) fail_now("unexpected_result");
            else begin
               exp_t r;
               r = rq.pop_front();
               check("result_value", {8'd0, res3}, r.res);
               check("result_cycle", cyc, r.cyc);
            end
            check("busy_in_done", {31'd0, busy3}, 32'd1);
         end else if (rv3 && prev_rv) begin
            check("result_hold", {8'd0, res3}, {8'd0, held});
         end
         prev_rv = rv3;
         held    = res3;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      tick();
      tick();
      check_reset_outputs("reset");
      check("reset_busy1", {31'd0, busy1}, 32'd0);

      // All ones, start in the first cycle after reset release: result 9.
      fill_const(8'd1, 8'd1);
      rst = 1'b0;
      issue_start();
      wait_result(0);

      // All 255, consumer stalls 20 cycles: result 585225 held stable.
      fill_const(8'd255, 8'd255);
      issue_start();
      wait_result(20);

      // kernel = x*3+y+1, pixel = 2 -> 90; a start during ISSUE is ignored.
      for (int x = 0; x < 3; x++)
         for (int y = 0; y < 3; y++) begin
            kmem[x][y] = 8'(x * 3 + y + 1);
            pmem[x][y] = 8'd2;
         end
      issue_start();
      tick();
      tick();
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      wait_result(1);

      // Accept with start in the same cycle returns to IDLE without a pass.
      fill_random();
      issue_start();
      wait_valid();
      ready3 = 1'b1;
      start3 = 1'b1;
      tick();
      ready3 = 1'b0;
      start3 = 1'b0;
      check("b2b_busy", {31'd0, busy3}, 32'd0);
      check("b2b_en_strobe", {31'd0, en3}, 32'd0);
      fill_random();
      issue_start();
      wait_result(0);

      // Reset in the fifth ISSUE cycle aborts the pass.
      fill_random();
      issue_start();
      repeat (4) tick();
      rst = 1'b1;
      tick();
      sq.delete();
      rq.delete();
      check_reset_outputs("abort");
      rst = 1'b0;
      fill_random();
      issue_start();
      wait_result(2);

      for (int n = 0; n < 5; n++) begin
         fill_random();
         issue_start();
         wait_result(int'($urandom_range(0, 5)));
      end

      // SIZE=1 instance: one strobe at (0,0) in cycle 1, result 42 in cycle 3.
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check("s1_strobe", {31'd0, en1}, 32'd1);
      check("s1_cur_x", {28'd0, cx1}, 32'd0);
      check("s1_cur_y", {28'd0, cy1}, 32'd0);
      check("s1_busy", {31'd0, busy1}, 32'd1);
      tick();
      check("s1_drain_strobe", {31'd0, en1}, 32'd0);
      check("s1_drain_valid", {31'd0, rv1}, 32'd0);
      tick();
      check("s1_valid", {31'd0, rv1}, 32'd1);
      check("s1_result", {8'd0, res1}, 32'd42);
      ready1 = 1'b1;
      tick();
      ready1 = 1'b0;
      check("s1_idle_valid", {31'd0, rv1}, 32'd0);
      check("s1_idle_busy", {31'd0, busy1}, 32'd0);

      tick();
      check("strobe_queue_empty", sq.size(), 32'd0);
      check("result_queue_empty", rq.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 SIZE, 4'd3, kernel/window edge length; legal range 1..15; SIZE=0 unsupported.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  request one SIZE x SIZE multiply-accumulate pass; sampled only in IDLE.
REQ-005 busy  out  1  high in any state other than IDLE.
REQ-006 cur_x  out  4  first matrix index presented to the index/read block.
REQ-007 cur_y  out  4  second matrix index presented to the index/read block.
REQ-008 en_strobe  out  1  read request; index block registers kernel_v/pixel_v at this edge.
REQ-009 kernel_v  in  8  unsigned kernel element; valid one cycle after en_strobe.
REQ-010 pixel_v  in  8  unsigned pixel element; valid one cycle after en_strobe.
REQ-011 result  out  24  unsigned sum of kernel_v*pixel_v over the full window.
REQ-012 result_valid  out  1  result is stable and offered.
REQ-013 result_ready  in  1  consumer accepts result when high with result_valid.

Function
REQ-014 States: IDLE, ISSUE, DRAIN, DONE.
REQ-015 IDLE: start=1 -> ISSUE; accumulator cleared, cur_x=cur_y=0; start=0 -> stay.
REQ-016 ISSUE: en_strobe=1 every cycle; exactly SIZE*SIZE consecutive strobes.
REQ-017 Order: cur_y inner loop 0..SIZE-1, cur_x outer loop 0..SIZE-1, i.e. (0,0),(0,1)..(0,SIZE-1),(1,0)..(SIZE-1,SIZE-1).
REQ-018 Last index (SIZE-1,SIZE-1) strobed -> DRAIN next cycle.
REQ-019 Product pending flag set on each strobe; in the following cycle acc += kernel_v*pixel_v (16-bit product zero-extended to 24 bits).
REQ-020 DRAIN: en_strobe=0, accumulates final product, then DONE.
REQ-021 DONE: result_valid=1, result holds final acc; result_ready=1 -> IDLE next cycle.
REQ-022 Latency: start sampled in cycle 0 -> strobes in cycles 1..SIZE*SIZE -> DRAIN in cycle SIZE*SIZE+1 -> result_valid first high in cycle SIZE*SIZE+2.
REQ-023 result_valid held with result unchanged until accepted; no timeout.
REQ-024 start outside IDLE ignored, including start with result_ready in DONE (returns to IDLE, no new pass).
REQ-025 Outside ISSUE: en_strobe=0; cur_x/cur_y hold last value (0 after reset).
REQ-026 No overflow possible: 225*255*255 = 14,630,625 < 2^24.
REQ-027 SIZE=1: single strobe at (0,0); result_valid in cycle 3.

Reset
REQ-028 rst=1 at a clock edge: state=IDLE, acc=0, result=0, pending flag=0, cur_x=cur_y=0, en_strobe=0, result_valid=0, busy=0.
REQ-029 rst overrides all inputs, including start and result_ready, in the same cycle.
REQ-030 rst mid-pass aborts; no partial result ever offered.
REQ-031 First start honoured in the first cycle after rst deasserts.

Structure
REQ-032 Shared package: state enum (IDLE, ISSUE, DRAIN, DONE), ACC_W=24, IDX_W=4.
REQ-033 Sub-module matrix_index_counter: nested x/y counter with clear, enable, and last-index flag; parameterised by SIZE.
REQ-034 Registered outputs only; no combinational path from any input to any output.

Verification
REQ-035 SIZE=3, index block loaded with all kernel=1 and pixel=1, start pulse at cycle 0 -> strobes cycles 1..9 in REQ-017 order, result_valid at cycle 11, result=9.
REQ-036 SIZE=3, all elements 255 -> result=585225; result_ready held low 20 cycles -> result_valid and result stable throughout.
REQ-037 SIZE=3, kernel[x][y]=x*3+y+1, pixel=2 -> result=90; start re-pulsed during ISSUE -> ignored, exactly 9 strobes.
REQ-038 rst asserted in cycle 5 of ISSUE -> next cycle all outputs at reset values; new start gives a correct result from a cleared acc.
REQ-039 Back-to-back: accept in DONE with start=1 in the same cycle -> IDLE, no pass; start next cycle -> second pass with identical latency.
REQ-040 SIZE=1, kernel=7, pixel=6 -> one strobe at (0,0) in cycle 1, result=42 valid in cycle 3.
